// File: rtl/sd_data_master_pkg.sv
// ============================================================================
// Module : sd_data_master_pkg
// Brief  : Shared state encoding and constants for the SD Wishbone data mover
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sd_data_master_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_BUS    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam int c_dma_timeout = 255;
  localparam int c_word_inc    = 4;

endpackage

`default_nettype wire

// File: rtl/sd_data_master.sv
// ============================================================================
// Module : sd_data_master
// Brief  : Wishbone classic master moving words between memory and the SD
//          controller TX/RX data FIFOs, one single cycle per word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_data_master
  import sd_data_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = c_dma_timeout
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              dir_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] m_wb_adr_o,
  output logic [31:0]       m_wb_dat_o,
  input  logic [31:0]       m_wb_dat_i,
  output logic [3:0]        m_wb_sel_o,
  output logic              m_wb_we_o,
  output logic              m_wb_cyc_o,
  output logic              m_wb_stb_o,
  input  logic              m_wb_ack_i,
  input  logic              m_wb_err_i,
  output logic [31:0]       tx_dat_o,
  output logic              tx_we_o,
  input  logic              tx_full_i,
  input  logic [31:0]       rx_dat_i,
  output logic              rx_rd_o,
  input  logic              rx_empty_i
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t              r_state,  w_state;
  logic [ADDR_W-1:0]   r_adr,    w_adr;
  logic [LEN_W-1:0]    r_rem,    w_rem;
  logic                r_dir,    w_dir;
  logic                r_err,    w_err;
  logic [TMR_W-1:0]    r_timer,  w_timer;
  logic                r_cyc,    w_cyc;
  logic                r_we,     w_we;
  logic [31:0]         r_wdat,   w_wdat;
  logic [31:0]         r_txdat,  w_txdat;
  logic                r_txwe,   w_txwe;
  logic                r_rxrd,   w_rxrd;
  logic                r_busy,   w_busy;
  logic                r_done,   w_done;
  logic                r_erro,   w_erro;
  logic                w_fifo_ok;

  assign w_fifo_ok = r_dir ? !rx_empty_i : !tx_full_i;

  always_comb begin
    w_state = r_state;
    w_adr   = r_adr;
    w_rem   = r_rem;
    w_dir   = r_dir;
    w_err   = r_err;
    w_timer = r_timer;
    w_cyc   = r_cyc;
    w_we    = r_we;
    w_wdat  = r_wdat;
    w_txdat = r_txdat;
    w_txwe  = 1'b0;
    w_rxrd  = 1'b0;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_erro  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_adr   = addr_i & ~ADDR_W'(3);
          w_rem   = len_i;
          w_dir   = dir_i;
          w_err   = 1'b0;
          w_busy  = 1'b1;
          w_state = (len_i == '0) ? S_FINISH : S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_i) begin
          w_err   = 1'b1;
          w_state = S_FINISH;
        end else if (w_fifo_ok) begin
          // RX word is popped together with the first bus cycle so it can't be lost
          if (r_dir) begin
            w_wdat = rx_dat_i;
            w_rxrd = 1'b1;
          end
          w_cyc   = 1'b1;
          w_we    = r_dir;
          w_timer = '0;
          w_state = S_BUS;
        end
      end
      S_BUS: begin
        if (m_wb_err_i) begin
          w_cyc   = 1'b0;
          w_we    = 1'b0;
          w_err   = 1'b1;
          w_state = S_FINISH;
        end else if (m_wb_ack_i) begin
          w_cyc = 1'b0;
          w_we  = 1'b0;
          if (!r_dir) begin
            w_txdat = m_wb_dat_i;
            w_txwe  = 1'b1;
          end
          w_adr = r_adr + ADDR_W'(c_word_inc);
          w_rem = r_rem - LEN_W'(1);
          if (abort_i) begin
            w_err   = 1'b1;
            w_state = S_FINISH;
          end else begin
            w_state = (r_rem == LEN_W'(1)) ? S_FINISH : S_WAIT;
          end
        end else if (abort_i || (r_timer == TMR_W'(TIMEOUT - 1))) begin
          w_cyc   = 1'b0;
          w_we    = 1'b0;
          w_err   = 1'b1;
          w_state = S_FINISH;
        end else begin
          w_timer = r_timer + TMR_W'(1);
        end
      end
      S_FINISH: begin
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_erro  = r_err;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_adr   <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
      r_timer <= '0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_wdat  <= '0;
      r_txdat <= '0;
      r_txwe  <= 1'b0;
      r_rxrd  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_erro  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_adr   <= w_adr;
      r_rem   <= w_rem;
      r_dir   <= w_dir;
      r_err   <= w_err;
      r_timer <= w_timer;
      r_cyc   <= w_cyc;
      r_we    <= w_we;
      r_wdat  <= w_wdat;
      r_txdat <= w_txdat;
      r_txwe  <= w_txwe;
      r_rxrd  <= w_rxrd;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_erro  <= w_erro;
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_erro;
  assign m_wb_adr_o = r_adr;
  assign m_wb_dat_o = r_wdat;
  assign m_wb_sel_o = 4'hF;
  assign m_wb_we_o  = r_we;
  assign m_wb_cyc_o = r_cyc;
  assign m_wb_stb_o = r_cyc;
  assign tx_dat_o   = r_txdat;
  assign tx_we_o    = r_txwe;
  assign rx_rd_o    = r_rxrd;

endmodule

`default_nettype wire

// File: tb/tb_sd_data_master.sv
// ============================================================================
// Module : tb_sd_data_master
// Brief  : Directed table-driven bench for sd_data_master with a Wishbone
//          slave model and TX/RX FIFO models.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sd_data_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, dir_i, abort_i;
  logic [31:0] addr_i;
  logic [7:0]  len_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_ack_i, m_wb_err_i;
  logic [31:0] tx_dat_o;
  logic        tx_we_o, tx_full_i;
  logic [31:0] rx_dat_m = 32'h0;
  logic        rx_rd_o;
  logic        rx_empty_m = 1'b1;

  sd_data_master #(.ADDR_W(32), .LEN_W(8), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .dir_i(dir_i),
    .addr_i(addr_i), .len_i(len_i), .abort_i(abort_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .m_wb_adr_o(m_wb_adr_o),
    .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i), .m_wb_sel_o(m_wb_sel_o),
    .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
    .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i), .tx_dat_o(tx_dat_o),
    .tx_we_o(tx_we_o), .tx_full_i(tx_full_i), .rx_dat_i(rx_dat_m),
    .rx_rd_o(rx_rd_o), .rx_empty_i(rx_empty_m)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // slave configuration (owned by the main process)
  int   ws_cfg = 0, err_word_cfg = -1, rx_fill_cfg = 0, run_id = 0;
  logic never_ack_cfg = 1'b0;

  // Wishbone slave: data word k returns 0xA0+k; ack after ws_cfg wait states
  int wait_cnt = 0, word_idx = 0, slv_id = 0;
  assign m_wb_ack_i = m_wb_cyc_o && m_wb_stb_o && !never_ack_cfg && (wait_cnt == ws_cfg);
  assign m_wb_err_i = m_wb_cyc_o && m_wb_stb_o && (word_idx == err_word_cfg);
  assign m_wb_dat_i = 32'hA0 + 32'(word_idx);

  always @(posedge clk) begin
    if (slv_id != run_id) begin
      slv_id   <= run_id;
      wait_cnt <= 0;
      word_idx <= 0;
    end else if (m_wb_cyc_o && m_wb_stb_o) begin
      if (m_wb_ack_i || m_wb_err_i) begin
        wait_cnt <= 0;
        word_idx <= word_idx + 1;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // monitor and RX FIFO model
  logic [31:0] ack_adr[$], ack_dat[$], tx_log[$], rx_q[$];
  logic        ack_we[$];
  logic [3:0]  ack_sel[$];
  int          mon_id = 0, rx_pops = 0, cyc_cycles = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (mon_id != run_id) begin
      mon_id = run_id;
      ack_adr.delete(); ack_dat.delete(); ack_we.delete(); ack_sel.delete();
      tx_log.delete(); rx_q.delete();
      rx_pops = 0; cyc_cycles = 0; done_cnt = 0;
      for (int k = 0; k < rx_fill_cfg; k++) rx_q.push_back(32'h11 * 32'(k + 1));
    end else begin
      if (m_wb_cyc_o) cyc_cycles++;
      if (done_o) done_cnt++;
      if (m_wb_ack_i && !m_wb_err_i) begin
        ack_adr.push_back(m_wb_adr_o);
        ack_dat.push_back(m_wb_dat_o);
        ack_we.push_back(m_wb_we_o);
        ack_sel.push_back(m_wb_sel_o);
      end
      if (tx_we_o) tx_log.push_back(tx_dat_o);
      if (rx_rd_o) begin
        rx_pops++;
        if (rx_q.size() > 0) void'(rx_q.pop_front());
      end
    end
    rx_empty_m = (rx_q.size() == 0);
    rx_dat_m   = (rx_q.size() > 0) ? rx_q[0] : 32'h0;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        dir;
    logic [31:0] addr;
    logic [7:0]  len;
    int          ws;
    int          err_word;
    logic        never_ack;
    int          full_from;
    int          full_to;
    int          abort_at;
    int          exp_lat;
    logic        exp_err;
    int          exp_words;
    int          exp_rx_pops;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input int idx);
    int   r, c0, lat, overlap, nchk;
    logic got_err, seen;
    logic [31:0] base;
    ws_cfg        = v.ws;
    err_word_cfg  = v.err_word;
    never_ack_cfg = v.never_ack;
    rx_fill_cfg   = v.dir ? int'(v.len) : 0;
    run_id++;
    @(negedge clk);
    @(negedge clk);
    c0 = cyc_cnt;
    start_i = 1'b1; dir_i = v.dir; addr_i = v.addr; len_i = v.len;
    tx_full_i = (0 >= v.full_from && 0 <= v.full_to);
    abort_i   = (v.abort_at == 0);
    seen = 1'b0; overlap = 0; lat = -1; got_err = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      r = cyc_cnt - c0;
      start_i = 1'b0;
      if (m_wb_cyc_o && tx_full_i) overlap++;
      if (done_o) begin
        seen = 1'b1; lat = r; got_err = err_o;
      end
      tx_full_i = (r >= v.full_from && r <= v.full_to);
      abort_i   = (r == v.abort_at);
    end
    tx_full_i = 1'b0;
    abort_i   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("v%0d done_seen", idx), 32'(seen), 32'd1);
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d err", idx), 32'(got_err), 32'(v.exp_err));
    chk($sformatf("v%0d words", idx), 32'(ack_adr.size()), 32'(v.exp_words));
    chk($sformatf("v%0d tx_pushes", idx), 32'(tx_log.size()), v.dir ? 32'd0 : 32'(v.exp_words));
    chk($sformatf("v%0d rx_pops", idx), 32'(rx_pops), 32'(v.exp_rx_pops));
    chk($sformatf("v%0d cyc_cycles", idx), 32'(cyc_cycles), 32'(v.exp_cyc));
    chk($sformatf("v%0d cyc_while_full", idx), 32'(overlap), 32'd0);
    chk($sformatf("v%0d done_pulses", idx), 32'(done_cnt), 32'd1);
    base = v.addr & 32'hFFFF_FFFC;
    nchk = (ack_adr.size() < v.exp_words) ? ack_adr.size() : v.exp_words;
    for (int k = 0; k < nchk; k++) begin
      chk($sformatf("v%0d w%0d adr", idx, k), ack_adr[k], base + 32'(4 * k));
      chk($sformatf("v%0d w%0d we", idx, k), 32'(ack_we[k]), 32'(v.dir));
      chk($sformatf("v%0d w%0d sel", idx, k), 32'(ack_sel[k]), 32'hF);
      if (v.dir) chk($sformatf("v%0d w%0d wdat", idx, k), ack_dat[k], 32'h11 * 32'(k + 1));
    end
    if (!v.dir) begin
      for (int k = 0; k < tx_log.size() && k < v.exp_words; k++)
        chk($sformatf("v%0d w%0d txdat", idx, k), tx_log[k], 32'hA0 + 32'(k));
    end
  endtask

  initial begin
    vec_t after;
    bit   got_cyc;
    rst = 1'b1; start_i = 1'b0; dir_i = 1'b0; addr_i = '0; len_i = '0;
    abort_i = 1'b0; tx_full_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    chk("rst cyc", 32'(m_wb_cyc_o), 32'd0);
    chk("rst stb", 32'(m_wb_stb_o), 32'd0);
    chk("rst we", 32'(m_wb_we_o), 32'd0);
    chk("rst sel", 32'(m_wb_sel_o), 32'hF);
    chk("rst adr", m_wb_adr_o, 32'd0);
    chk("rst tx_we", 32'(tx_we_o), 32'd0);
    chk("rst rx_rd", 32'(rx_rd_o), 32'd0);

    //          dir addr           len ws ew  na  ff  ft  ab  lat err wd rxp cyc
    vecs[0] = '{1'b0, 32'h0000_1000, 8'd4, 0, -1, 1'b0, -1, -2, -1, 10, 1'b0, 4, 0, 4};
    vecs[1] = '{1'b1, 32'h0000_2000, 8'd3, 2, -1, 1'b0, -1, -2, -1, 14, 1'b0, 3, 3, 9};
    vecs[2] = '{1'b0, 32'h0000_3000, 8'd4, 0, -1, 1'b0,  3,  7, -1, 15, 1'b0, 4, 0, 4};
    vecs[3] = '{1'b0, 32'h0000_4000, 8'd2, 0, -1, 1'b1, -1, -2, -1, 19, 1'b1, 0, 0, 16};
    vecs[4] = '{1'b0, 32'h0000_5000, 8'd4, 0,  1, 1'b0, -1, -2, -1,  6, 1'b1, 1, 0, 2};
    vecs[5] = '{1'b1, 32'h0000_6000, 8'd4, 0, -1, 1'b0, -1, -2,  3,  5, 1'b1, 1, 1, 1};
    vecs[6] = '{1'b0, 32'h0000_7000, 8'd0, 0, -1, 1'b0, -1, -2, -1,  2, 1'b0, 0, 0, 0};
    vecs[7] = '{1'b0, 32'h0000_8000, 8'd4, 0, -1, 1'b0, -1, -2,  2,  4, 1'b1, 1, 0, 1};
    vecs[8] = '{1'b0, 32'hFFFF_FFFA, 8'd3, 0, -1, 1'b0, -1, -2, -1,  8, 1'b0, 3, 0, 3};

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // reset asserted while the slave is stretching a bus cycle
    ws_cfg = 5; err_word_cfg = -1; never_ack_cfg = 1'b0; rx_fill_cfg = 0;
    run_id++;
    @(negedge clk);
    @(negedge clk);
    start_i = 1'b1; dir_i = 1'b0; addr_i = 32'h9000; len_i = 8'd4;
    @(negedge clk);
    start_i = 1'b0;
    got_cyc = 1'b0;
    for (int k = 0; k < 20 && !got_cyc; k++) begin
      @(negedge clk);
      got_cyc = m_wb_cyc_o;
    end
    chk("rstmid reached_bus", 32'(got_cyc), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid cyc", 32'(m_wb_cyc_o), 32'd0);
    chk("rstmid stb", 32'(m_wb_stb_o), 32'd0);
    chk("rstmid busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid no_done", 32'(done_cnt), 32'd0);
    chk("rstmid no_tx", 32'(tx_log.size()), 32'd0);
    after = '{1'b0, 32'h0000_A000, 8'd2, 0, -1, 1'b0, -1, -2, -1, 6, 1'b0, 2, 0, 2};
    run_vec(after, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sd_data_master.md
# sd_data_master

Wishbone master data mover for the SD card controller: the bus-initiator counterpart of the controller's Wishbone slave register port. Given a start address and word count from the descriptor logic, it issues single classic Wishbone cycles to system memory. In read-from-memory direction it pushes the fetched words into the TX data FIFO. In write-to-memory direction it pops words from the RX data FIFO and writes them out. It reports completion, abort and bus error back to the controller.

## Interface
- ADDR_W, 32, Wishbone address width
- LEN_W, 8, word-count width (max 255 words; a 512-byte block is 128)
- TIMEOUT, 255, maximum cycles to wait for ack/err per bus cycle
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start transfer; sampled only in IDLE
- dir_i  in  1  0 = memory→TX FIFO (card write), 1 = RX FIFO→memory (card read)
- addr_i  in  ADDR_W  start byte address; bits [1:0] forced to 0
- len_i  in  LEN_W  number of 32-bit words
- abort_i  in  1  abort in-flight transfer
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; 1 = bus error, timeout or abort
- m_wb_adr_o  out  ADDR_W;  m_wb_dat_o  out  32;  m_wb_dat_i  in  32
- m_wb_sel_o  out  4 (always 4'hF);  m_wb_we_o  out  1
- m_wb_cyc_o  out  1;  m_wb_stb_o  out  1;  m_wb_ack_i  in  1;  m_wb_err_i  in  1
- tx_dat_o  out  32;  tx_we_o  out  1;  tx_full_i  in  1
- rx_dat_i  in  32 (first-word-fall-through, valid when !rx_empty_i);  rx_rd_o  out  1;  rx_empty_i  in  1

## Operation
- Reset: all outputs 0, except m_wb_sel_o = 4'hF. State IDLE, counters 0.
- States:
  - IDLE: on start_i, latch addr (low bits cleared), len and dir; assert busy_o.
    - len_i = 0 → FINISH with err = 0.
    - otherwise → WAIT.
  - WAIT: proceed when the FIFO is ready. dir = 0 needs !tx_full_i; dir = 1 needs !rx_empty_i.
    - For dir = 1: latch rx_dat_i into m_wb_dat_o and pulse rx_rd_o for one cycle.
    - Assert cyc/stb; m_wb_we_o = dir → BUS.
  - BUS: hold cyc, stb, adr, dat and we stable until ack or err.
    - On m_wb_ack_i: drop cyc/stb next cycle.
    - For dir = 0: register m_wb_dat_i into tx_dat_o and pulse tx_we_o the following cycle.
    - addr += 4, remaining −= 1; remaining reaches 0 → FINISH, else → WAIT.
    - On m_wb_err_i, or timer reaching TIMEOUT: drop cyc/stb → FINISH with err = 1. A word that failed is not counted and not pushed.
  - FINISH: done_o = 1 for one cycle, err_o as recorded; busy_o deasserts → IDLE.
- Timer: cleared on entry to BUS, increments each BUS cycle without ack/err.
- abort_i in WAIT or BUS → FINISH with err = 1; cyc/stb drop the next cycle; no FIFO pop or push occurs for the aborted word. abort_i in IDLE or FINISH is ignored.
- Simultaneous ack and err: err wins.
- Simultaneous abort_i and ack: the ack completes the word (push/count), then FINISH with err = 1.
- start_i while busy is ignored.
- Address wrap past 2^ADDR_W wraps modulo; no check.
- Reset mid-transfer: cyc/stb drop asynchronously; no done pulse.

## Timing
- cyc/stb are registered: asserted the cycle after WAIT sees the FIFO ready.
- rx_rd_o pulses in the same cycle that cyc/stb first go high.
- Per word with zero-wait-state slave: WAIT, BUS (ack), back to WAIT = 2 cycles/word.
- N words with FIFO always ready: start to done_o = 2N + 2 cycles.
- tx_we_o occurs exactly 1 cycle after the ack cycle.
- cyc is deasserted for at least 1 cycle between words; no bursts, no CTI/BTE.

## Structure
- Add to sd_defines.v:
  - state encodings (IDLE, WAIT, BUS, FINISH, 2 bits)
  - `SD_DMA_TIMEOUT default
  - word increment constant (4)
- Single module; no sub-module needed. The timeout counter and word counter stay inline.

## Test plan
- dir = 0, addr = 0x1000, len = 4, slave acks with 0-wait returning 0xA0..0xA3 → tx FIFO gets A0, A1, A2, A3; addresses 0x1000/04/08/0C; done_o at cycle 10, err_o = 0.
- dir = 1, len = 3, RX FIFO holds 0x11, 0x22, 0x33, slave inserts 2 wait states → three writes with we = 1, sel = F, data in order; 3 rx_rd_o pulses; done without error.
- dir = 0, len = 4, tx_full_i high for 5 cycles before word 2 → no cyc during full; all 4 words delivered; done at 2N + 2 + 5.
- Slave never acks, TIMEOUT = 16 → cyc drops after 16 BUS cycles; done_o with err_o = 1; no tx_we_o.
- m_wb_err_i on word 2 of 4, then a separate run with abort_i in WAIT → both end with err_o = 1, exactly 1 word transferred, no extra rx_rd_o/tx_we_o. A following start with len = 0 gives done next+1 cycle, err = 0, no bus cycle.
- Assert wb_rst_i mid-BUS → cyc/stb/busy 0 immediately; no done_o; next start behaves normally.
